// File: rtl/irq_dispatch_ctrl.sv
// Interrupt request/priority/dispatch controller: IF/IE registers, delayed-EI master
// enable and a late-priority vector handshake with the sequencer.
module irq_dispatch_ctrl #(
    parameter int unsigned NCH      = 8,
    parameter logic [7:0]  VEC_BASE = 8'h40,
    parameter logic [7:0]  VEC_STEP = 8'd8
) (
    input  logic           clk_i,
    input  logic           sync_res_i,
    input  logic [NCH-1:0] irq_trig_i,
    input  logic           reg_sel_i,
    input  logic           reg_wr_i,
    input  logic [NCH-1:0] reg_wdata_i,
    output logic [NCH-1:0] reg_rdata_o,
    input  logic           ei_i,
    input  logic           di_i,
    input  logic           reti_i,
    input  logic           insn_end_i,
    input  logic           dispatch_i,
    input  logic           ack_stb_i,
    output logic           int_req_o,
    output logic           wake_o,
    output logic           ime_o,
    output logic [7:0]     vec_o,
    output logic           vec_valid_o,
    output logic [NCH-1:0] irq_ack_o
);

    localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_VEC} state_e;

    state_e         state_q;
    logic [NCH-1:0] prev_q, if_q, if_d, ie_q, ie_d, irq_ack_q;
    logic [NCH-1:0] pend, trig_edge, sel_onehot;
    logic           ime_q, ime_d, ei_pend_q, ei_pend_d, vec_valid_q;
    logic [7:0]     vec_q, vec_calc;
    logic [IW-1:0]  sel_idx;
    logic           take;

    assign pend      = if_q & ie_q;
    assign trig_edge = irq_trig_i & ~prev_q;
    assign take      = (state_q == ST_IDLE) && dispatch_i && int_req_o;

    assign reg_rdata_o = reg_sel_i ? ie_q : if_q;
    assign wake_o      = |pend;
    assign int_req_o   = ime_q & wake_o;
    assign ime_o       = ime_q;
    assign vec_o       = vec_q;
    assign vec_valid_o = vec_valid_q;
    assign irq_ack_o   = irq_ack_q;

    // Lowest pending index wins; scanning downwards leaves it as the final assignment.
    always_comb begin
        sel_idx    = '0;
        sel_onehot = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel_idx       = IW'(i);
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
            end
        end
        vec_calc = VEC_BASE + 8'(sel_idx) * VEC_STEP;
    end

    always_comb begin
        if_d = if_q;
        ie_d = ie_q;
        if (reg_wr_i) begin
            if (reg_sel_i) ie_d = reg_wdata_i;
            else           if_d = reg_wdata_i;
        end
        // A fresh edge on the acknowledged line survives its own clear.
        if_d = (if_d & ~irq_ack_q) | trig_edge;
    end

    // Later assignments take precedence: DI over dispatch entry over RETI over EI.
    always_comb begin
        ime_d     = ime_q;
        ei_pend_d = ei_pend_q;
        if (ei_pend_q && insn_end_i) begin
            ime_d     = 1'b1;
            ei_pend_d = 1'b0;
        end
        if (ei_i) ei_pend_d = 1'b1;
        if (reti_i) begin
            ime_d     = 1'b1;
            ei_pend_d = 1'b0;
        end
        if (take || di_i) begin
            ime_d     = 1'b0;
            ei_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (sync_res_i) begin
            prev_q    <= '1;
            if_q      <= '0;
            ie_q      <= '0;
            ime_q     <= 1'b0;
            ei_pend_q <= 1'b0;
        end else begin
            prev_q    <= irq_trig_i;
            if_q      <= if_d;
            ie_q      <= ie_d;
            ime_q     <= ime_d;
            ei_pend_q <= ei_pend_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (sync_res_i) begin
            state_q     <= ST_IDLE;
            vec_q       <= 8'h00;
            vec_valid_q <= 1'b0;
            irq_ack_q   <= '0;
        end else begin
            vec_valid_q <= 1'b0;
            irq_ack_q   <= '0;
            case (state_q)
                ST_IDLE: if (take) state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (ack_stb_i) begin
                        state_q     <= ST_VEC;
                        vec_valid_q <= 1'b1;
                        irq_ack_q   <= sel_onehot;
                        // Nothing left pending at sample time: cancelled entry uses vector 0.
                        vec_q       <= (|pend) ? vec_calc : 8'h00;
                    end
                end
                ST_VEC:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_dispatch_ctrl.sv
// Bench for irq_dispatch_ctrl: an 8-channel default instance and a 16-channel wrapping
// instance share stimulus and are each checked against a cycle-level behavioural model.
module tb_irq_dispatch_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        sync_res = 1'b0;
    logic [15:0] trig = 16'h0020;
    logic        reg_sel = 1'b0, reg_wr = 1'b0;
    logic [15:0] wdata = 16'h0000;
    logic        ei = 1'b0, di = 1'b0, reti = 1'b0, insn_end = 1'b0;
    logic        dispatch = 1'b0, ack_stb = 1'b0;

    logic [7:0]  a_rdata, a_ack, a_vec;
    logic        a_int_req, a_wake, a_ime, a_vv;
    logic [15:0] b_rdata, b_ack;
    logic [7:0]  b_vec;
    logic        b_int_req, b_wake, b_ime, b_vv;

    irq_dispatch_ctrl u_dut8 (
        .clk_i(clk), .sync_res_i(sync_res), .irq_trig_i(trig[7:0]),
        .reg_sel_i(reg_sel), .reg_wr_i(reg_wr), .reg_wdata_i(wdata[7:0]),
        .reg_rdata_o(a_rdata), .ei_i(ei), .di_i(di), .reti_i(reti),
        .insn_end_i(insn_end), .dispatch_i(dispatch), .ack_stb_i(ack_stb),
        .int_req_o(a_int_req), .wake_o(a_wake), .ime_o(a_ime), .vec_o(a_vec),
        .vec_valid_o(a_vv), .irq_ack_o(a_ack)
    );

    irq_dispatch_ctrl #(.NCH(16), .VEC_BASE(8'hF0), .VEC_STEP(8'h10)) u_dut16 (
        .clk_i(clk), .sync_res_i(sync_res), .irq_trig_i(trig),
        .reg_sel_i(reg_sel), .reg_wr_i(reg_wr), .reg_wdata_i(wdata),
        .reg_rdata_o(b_rdata), .ei_i(ei), .di_i(di), .reti_i(reti),
        .insn_end_i(insn_end), .dispatch_i(dispatch), .ack_stb_i(ack_stb),
        .int_req_o(b_int_req), .wake_o(b_wake), .ime_o(b_ime), .vec_o(b_vec),
        .vec_valid_o(b_vv), .irq_ack_o(b_ack)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model, one slot per instance. phase: 0 idle, 1 awaiting ack, 2 vector out.
    int          nch_c[2]  = '{8, 16};
    int          base_c[2] = '{'h40, 'hF0};
    int          step_c[2] = '{8, 'h10};
    logic [15:0] m_if[2], m_ie[2], m_prev[2], m_ack[2];
    logic        m_ime[2], m_eip[2], m_vv[2];
    logic [7:0]  m_vec[2];
    int          m_phase[2];

    task automatic model_step(input int u);
        logic [15:0] mask, pend, edges, nif, nie, nack;
        logic        req, nime, neip, nvv;
        logic [7:0]  nvec;
        int          nphase, k;
        mask = 16'((32'h1 << nch_c[u]) - 1);
        if (sync_res) begin
            m_if[u] = 0; m_ie[u] = 0; m_prev[u] = mask; m_ack[u] = 0;
            m_ime[u] = 0; m_eip[u] = 0; m_vv[u] = 0; m_vec[u] = 0; m_phase[u] = 0;
            return;
        end
        pend  = m_if[u] & m_ie[u];
        req   = m_ime[u] && (pend != 0);
        edges = trig & ~m_prev[u] & mask;
        nif = m_if[u];
        nie = m_ie[u];
        if (reg_wr) begin
            if (reg_sel) nie = wdata & mask;
            else         nif = wdata & mask;
        end
        nif = (nif & ~m_ack[u]) | edges;
        if (di || (m_phase[u] == 0 && dispatch && req)) begin
            nime = 0; neip = 0;
        end else if (reti) begin
            nime = 1; neip = 0;
        end else begin
            nime = m_ime[u] | (m_eip[u] & insn_end);
            neip = ei ? 1'b1 : ((m_eip[u] && insn_end) ? 1'b0 : m_eip[u]);
        end
        nvv = 0; nack = 0; nvec = m_vec[u]; nphase = m_phase[u];
        case (m_phase[u])
            0: if (dispatch && req) nphase = 1;
            1: if (ack_stb) begin
                nphase = 2;
                nvv    = 1;
                k      = -1;
                for (int i = 0; i < nch_c[u]; i++)
                    if (k < 0 && pend[i]) k = i;
                if (k >= 0) begin
                    nvec = 8'((base_c[u] + k * step_c[u]) % 256);
                    nack = 16'(1 << k);
                end else begin
                    nvec = 8'h00;
                end
            end
            default: nphase = 0;
        endcase
        m_if[u] = nif; m_ie[u] = nie; m_prev[u] = trig & mask;
        m_ime[u] = nime; m_eip[u] = neip;
        m_vv[u] = nvv; m_ack[u] = nack; m_vec[u] = nvec; m_phase[u] = nphase;
    endtask

    task automatic cmp_unit(input int u, input logic intr, input logic wk, input logic ime,
                            input logic [7:0] vec, input logic vv, input logic [15:0] ack,
                            input logic [15:0] rdata);
        string p;
        p = (u == 0) ? "n8_" : "n16_";
        check({p, "int_req"}, 32'(intr), 32'(m_ime[u] && ((m_if[u] & m_ie[u]) != 0)));
        check({p, "wake"},    32'(wk),   32'((m_if[u] & m_ie[u]) != 0));
        check({p, "ime"},     32'(ime),  32'(m_ime[u]));
        check({p, "vec"},     32'(vec),  32'(m_vec[u]));
        check({p, "vec_valid"}, 32'(vv), 32'(m_vv[u]));
        check({p, "irq_ack"}, 32'(ack),  32'(m_ack[u]));
        check({p, "rdata"},   32'(rdata), 32'(reg_sel ? m_ie[u] : m_if[u]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step(0);
        model_step(1);
        cmp_unit(0, a_int_req, a_wake, a_ime, a_vec, a_vv, {8'h00, a_ack}, {8'h00, a_rdata});
        cmp_unit(1, b_int_req, b_wake, b_ime, b_vec, b_vv, b_ack, b_rdata);
        sync_res = 0; reg_wr = 0; ei = 0; di = 0; reti = 0;
        insn_end = 0; dispatch = 0; ack_stb = 0;
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            m_if[u] = 0; m_ie[u] = 0; m_prev[u] = 16'hFFFF; m_ack[u] = 0;
            m_ime[u] = 0; m_eip[u] = 0; m_vv[u] = 0; m_vec[u] = 0; m_phase[u] = 0;
        end

        // Reset with line 5 held high; it must not register once reset drops.
        sync_res = 1; tick();
        check("rst_ime", 32'(a_ime), 0);
        check("rst_vec", 32'(a_vec), 0);
        check("rst_int_req", 32'(a_int_req), 0);
        tick();
        check("held_line_if", 32'(a_rdata), 0);
        check("held_line_if16", 32'(b_rdata), 0);

        // Basic dispatch of channel 2.
        trig = 16'h0000; tick();
        reg_sel = 1; reg_wr = 1; wdata = 16'h001F; tick();
        reti = 1; tick();
        reg_sel = 0; trig[2] = 1; tick();
        check("t1_int_req", 32'(a_int_req), 1);
        dispatch = 1; tick();
        check("t1_ime_cleared", 32'(a_ime), 0);
        ack_stb = 1; tick();
        check("t1_vec", 32'(a_vec), 32'h50);
        check("t1_vv", 32'(a_vv), 1);
        check("t1_ack", 32'(a_ack), 32'h04);
        tick();
        check("t1_if", 32'(a_rdata), 0);

        // Late priority: channel 0 arrives while waiting for ACK_STB.
        trig[2] = 0; reti = 1; tick();
        trig[2] = 1; tick();
        dispatch = 1; tick();
        trig[0] = 1; tick();
        ack_stb = 1; tick();
        check("t2_vec", 32'(a_vec), 32'h40);
        check("t2_ack", 32'(a_ack), 32'h01);
        tick();
        check("t2_if", 32'(a_rdata), 32'h04);

        // Cancel: IE cleared between DISPATCH and ACK_STB.
        trig = 16'h0000; reti = 1; tick();
        dispatch = 1; tick();
        reg_sel = 1; reg_wr = 1; wdata = 16'h0000; tick();
        ack_stb = 1; tick();
        check("t3_vec", 32'(a_vec), 0);
        check("t3_ack", 32'(a_ack), 0);
        reg_sel = 0; tick();
        check("t3_if", 32'(a_rdata), 32'h04);
        check("t3_ime", 32'(a_ime), 0);

        // EI delay, and DI beating EI.
        reg_sel = 1; reg_wr = 1; wdata = 16'h001F; tick();
        reg_sel = 0; di = 1; tick();
        ei = 1; tick();
        insn_end = 1;
        check("t4_req_at_insn_end", 32'(a_int_req), 0);
        tick();
        check("t4_req_after", 32'(a_int_req), 1);
        di = 1; tick();
        ei = 1; di = 1; tick();
        insn_end = 1; tick();
        insn_end = 1; tick();
        check("t4_ei_di_ime", 32'(a_ime), 0);

        // Channel 3 on both instances; the 16-channel vector wraps. Edge during the clear.
        reg_wr = 1; wdata = 16'h0000; tick();
        trig[3] = 1; tick();
        trig[3] = 0; reti = 1; tick();
        dispatch = 1; tick();
        ack_stb = 1; tick();
        check("t5_vec16", 32'(b_vec), 32'h20);
        check("t5_vec8", 32'(a_vec), 32'h58);
        check("t5_ack16", 32'(b_ack), 32'h0008);
        trig[3] = 1; tick();
        check("t5_if_kept16", 32'(b_rdata), 32'h0008);
        check("t5_if_kept8", 32'(a_rdata), 32'h08);

        // Reset while waiting for ACK_STB.
        reti = 1; tick();
        dispatch = 1; tick();
        check("t6_int_req_pre", 32'(a_int_req), 0);
        sync_res = 1; ack_stb = 1; tick();
        check("t6_vv", 32'(a_vv), 0);
        check("t6_ack", 32'(a_ack), 0);
        check("t6_if", 32'(a_rdata), 0);
        reg_sel = 1; #1;
        check("t6_ie", 32'(a_rdata), 0);
        reg_sel = 0;
        ack_stb = 1; tick();
        check("t6_vv_after", 32'(b_vv), 0);
        check("t6_held_if", 32'(b_rdata), 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            sync_res = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 16; i++)
                if ($urandom_range(0, 7) == 0) trig[i] = ~trig[i];
            reg_wr   = ($urandom_range(0, 9) == 0);
            reg_sel  = 1'($urandom_range(0, 1));
            wdata    = 16'($urandom);
            ei       = ($urandom_range(0, 15) == 0);
            di       = ($urandom_range(0, 39) == 0);
            reti     = ($urandom_range(0, 19) == 0);
            insn_end = ($urandom_range(0, 2) == 0);
            dispatch = ($urandom_range(0, 3) == 0);
            ack_stb  = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/irq_dispatch_ctrl.md
# irq_dispatch_ctrl

Parametrised interrupt request, priority and dispatch controller for the CPU bottom section. It generalises the fixed 8-line IRQ trigger/acknowledge path to NCH channels with a programmable vector base and stride. It adds IE/IF registers, delayed-EI master-enable semantics and a late-priority dispatch handshake with the sequencer. It sits between the peripheral trigger lines and the sequencer/address-bus logic, and supplies the vector placed on the low address byte during dispatch.

## Interface
- NCH, 8: number of interrupt channels, 1..16; index 0 has the highest priority.
- VEC_BASE, 8'h40: vector for channel 0.
- VEC_STEP, 8: vector stride per channel.

- CLK  in  1  single system clock, rising edge.
- SYNC_RES  in  1  reset, synchronous, active-high.
- IRQ_TRIG  in  NCH  request lines, rising-edge sensitive.
- REG_SEL  in  1  register select: 0 = IF, 1 = IE.
- REG_WR  in  1  write strobe for the selected register.
- REG_WDATA  in  NCH  write data.
- REG_RDATA  out  NCH  selected register, combinational.
- EI  in  1  enable-interrupts strobe (delayed effect).
- DI  in  1  disable-interrupts strobe (immediate effect).
- RETI  in  1  set IME immediately.
- INSN_END  in  1  instruction boundary strobe.
- DISPATCH  in  1  sequencer starts interrupt entry.
- ACK_STB  in  1  sequencer vector-sample cycle.
- INT_REQ  out  1  IME & |(IF & IE).
- WAKE  out  1  |(IF & IE), independent of IME (HALT exit).
- IME  out  1  master enable.
- VEC  out  8  dispatch vector.
- VEC_VALID  out  1  VEC is valid; one-cycle pulse.
- IRQ_ACK  out  NCH  one-hot acknowledge pulse.

## Operation
- Edge detect: prev <= IRQ_TRIG every cycle. A bit where IRQ_TRIG & ~prev is set in IF.
- IF/IE writes: REG_WR loads the selected register from REG_WDATA.
  - A trigger edge in the same cycle is ORed in after the write, so the set wins.
- IME control:
  - EI arms ei_pend.
  - IME rises on the clock after the first INSN_END strictly after the EI cycle. The INSN_END that sets IME still sees IME = 0, so exactly one further instruction executes before an interrupt can be taken.
  - DI clears IME and ei_pend immediately. DI and EI in the same cycle: DI wins.
  - RETI sets IME next clock and clears ei_pend.
- FSM states: IDLE, WAIT, VEC.
  - IDLE to WAIT: on DISPATCH & INT_REQ. IME and ei_pend are cleared. DISPATCH without INT_REQ is ignored.
  - WAIT: holds until ACK_STB. At ACK_STB the block samples p = IF & IE in that cycle (late priority). The lowest set index k is chosen.
    - If p == 0 the dispatch is cancelled: VEC = 8'h00 and IRQ_ACK = 0.
  - WAIT to VEC: VEC_VALID = 1 and VEC = VEC_BASE + k*VEC_STEP, truncated to 8 bits (wraps). IRQ_ACK[k] = 1 and IF[k] is cleared. Then return to IDLE.
  - A trigger edge on bit k in the clear cycle wins, so IF[k] stays 1.
  - DISPATCH while in WAIT or VEC is ignored.
- Outputs:
  - INT_REQ and WAKE are combinational from the registers.
  - VEC holds its last value outside VEC_VALID.
  - REG_RDATA bits above NCH do not exist.
  - Writing to IF/IE is legal in any state and affects the WAIT-state priority.

## Timing
- Reset values: IF = 0, IE = 0, IME = 0, ei_pend = 0, state = IDLE, VEC = 0, VEC_VALID = 0, IRQ_ACK = 0, INT_REQ = 0, WAKE = 0.
  - prev resets to all-ones, so a line already high at reset does not trigger.
- Trigger edge at cycle n: IF visible at n+1; INT_REQ/WAKE at n+1.
- EI at cycle e, first INSN_END at t > e: IME = 1 from t+1.
- DISPATCH at cycle d: IME = 0 from d+1. ACK_STB at cycle a >= d+1 gives VEC_VALID/IRQ_ACK at a+1 and IF cleared from a+2.
- Minimum dispatch: 2 cycles from DISPATCH to VEC_VALID.
- WAIT has no timeout.
- SYNC_RES mid-dispatch: next cycle is IDLE with all reset values. No IRQ_ACK is issued.

## Test plan
- Defaults: IE = 0x1F, IME = 1, rising edge on IRQ_TRIG[2] -> INT_REQ next cycle. DISPATCH then ACK_STB -> VEC = 0x50, IRQ_ACK = 0x04, IF = 0x00.
- Late priority: IF = 0x04 pending, DISPATCH, then an edge on bit 0 before ACK_STB -> VEC = 0x40, IRQ_ACK = 0x01, IF = 0x04 remains.
- Cancel: DISPATCH, then write IE = 0 before ACK_STB -> VEC = 0x00, IRQ_ACK = 0, IF unchanged, IME = 0.
- EI delay: EI, then INSN_END #1 with pending IRQ -> INT_REQ = 0 at INSN_END #1 and 1 on the next cycle. EI and DI together -> IME stays 0.
- Parameters NCH = 16, VEC_BASE = 0xF0, VEC_STEP = 0x10, channel 3 -> VEC = 0x20 (wrap). Edge on bit 3 coincident with its ack clear -> IF[3] = 1 afterwards.
- SYNC_RES asserted in WAIT -> IDLE, IF = IE = 0, no VEC_VALID. A line held high through reset -> no IF set.
